md_sequencer: RTL
=================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle sequencer for the EX-stage multiply/divide resources (mul, div).
//  Accepts one MULT/MULTU/DIV/DIVU op from EX and latches its operands.
//  Drives the mul/div handshakes and holds the pipeline via stallreq until the result exists.
//  Then issues a single HI/LO write. Sits beside the ALU in EX; stallreq ORs into stallreq_for_ex.
// PARAMETERS
//  MUL_LAT   2   cycles from mul operands valid to mul_result valid (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   asynchronous, active-low reset
//  flush        in   1   cancel in-flight op (exception/branch kill)
//  op_valid     in   1   EX holds a mul/div instruction this cycle
//  op_type      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src1, src2   in   32  rs / rt operand values
//  mul_signed   out  1   to mul: signed multiply
//  mul_ina/inb  out  32  to mul: latched operands
//  mul_result   in   64  from mul: {hi,lo}
//  div_start    out  1   to div: start/hold request
//  div_annul    out  1   to div: abort current division
//  div_signed   out  1   to div: signed divide
//  div_op1/op2  out  32  to div: latched dividend / divisor
//  div_result   in   64  from div: {remainder,quotient}
//  div_ready    in   1   from div: result valid
//  stallreq     out  1   hold IF..EX; combinational
//  hilo_we      out  1   one-cycle HI/LO write strobe
//  hi_wdata     out  32  value for HI
//  lo_wdata     out  32  value for LO
//  busy         out  1   FSM not IDLE
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE, count=0, operand/type regs=0; all outputs 0.
//  - States: IDLE, MUL, DIV, DONE. The state register, counter and latches update on the clk rising edge.
//  - IDLE: when op_valid=1 and flush=0:
//    - latch src1/src2/op_type;
//    - stallreq=1 combinationally in the same cycle.
//    - Next state: MULT/MULTU -> MUL (count=MUL_LAT-1); DIV/DIVU with src2!=0 -> DIV;
//      DIV/DIVU with src2==0 -> DONE (divide-by-zero path, no div access).
//  - MUL: mul_ina/inb/mul_signed are driven from the latches; stallreq=1; count decrements.
//    count==0 -> DONE and capture mul_result into a result reg.
//  - DIV: div_start=1 with div_op1/op2/div_signed from the latches; stallreq=1.
//    div_ready=1 -> DONE, capture div_result, and drop div_start in that cycle.
//  - DONE: hilo_we=1 and stallreq=0 for exactly one cycle, then -> IDLE.
//    - op_valid in DONE is ignored: the completing instruction leaves EX this cycle.
//    - A back-to-back op is accepted in the following IDLE cycle.
//  - Result mapping:
//    - mul: HI=mul_result[63:32], LO=mul_result[31:0].
//    - div: HI=remainder=div_result[63:32], LO=quotient=div_result[31:0].
//    - divide-by-zero: HI=src1, LO=32'hFFFF_FFFF.
//  - Latency (accept cycle = 0): hilo_we in cycle MUL_LAT+1 for mul; the cycle after div_ready for div;
//    cycle 1 for divide-by-zero.
//  - div_start/div_annul/hilo_we/stallreq are 0 in IDLE. Mul/div operand outputs hold their latched values.
//  - flush has priority over everything, in any state:
//    - next state IDLE, no hilo_we, stallreq=0 in that cycle;
//    - if the state is DIV, div_annul=1 for that cycle and div_start=0.
//  - flush together with op_valid in IDLE: op is not accepted.
//  - div_ready while not in DIV is ignored; mul_result outside MUL is ignored.
//  - Reset mid-operation: immediate return to IDLE, outputs 0, no partial HI/LO write.
// TESTING
//  - MULT src1=-3 (32'hFFFF_FFFD), src2=7, MUL_LAT=2 -> stallreq high cycles 0-2;
//    hilo_we cycle 3, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
//  - DIVU src1=100, src2=7, div_ready after 33 cycles -> div_start held until ready;
//    then hilo_we once, HI=2, LO=14; stallreq low on the write cycle.
//  - DIV src1=5, src2=0 -> div_start never asserted; hilo_we in cycle 1, HI=5, LO=32'hFFFF_FFFF.
//  - DIV in flight, flush at cycle 10 -> div_annul=1 for one cycle, state IDLE, no hilo_we,
//    stallreq=0.
//  - MULTU immediately followed by DIV (op_valid held) -> exactly two hilo_we pulses;
//    the second op is accepted the cycle after DONE.
//  - resetn pulsed low mid-MUL, asynchronous to clk -> all outputs 0 before the next edge;
//    busy=0 and no hilo_we after release.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle sequencer for the EX-stage multiply/divide units.
// Accepts one MULT/MULTU/DIV/DIVU op, drives the mul/div handshakes, stalls
// the pipeline until the result exists, then issues a single HI/LO write.
module md_sequencer #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy
);

    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [31:0]     src1_q,  src1_d;
    logic [31:0]     src2_q,  src2_d;
    logic [1:0]      type_q,  type_d;
    logic [63:0]     res_q,   res_d;

    // State, counter, operand latches and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            type_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            type_q  <= type_d;
            res_q   <= res_d;
        end
    end

    // Next-state, latch updates and handshake/stall outputs; flush wins over all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        type_d    = type_q;
        res_d     = res_q;
        stallreq  = 1'b0;
        hilo_we   = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        if (flush) begin
            state_d   = S_IDLE;
            div_annul = (state_q == S_DIV);
        end else begin
            case (state_q)
                S_IDLE: begin
                    // resetn gating keeps stallreq low while reset is held.
                    if (op_valid && resetn) begin
                        stallreq = 1'b1;
                        src1_d   = src1;
                        src2_d   = src2;
                        type_d   = op_type;
                        if (!op_type[1]) begin
                            state_d = S_MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                        end else if (src2 != '0) begin
                            state_d = S_DIV;
                        end else begin
                            // Divide by zero: result is known now, divider untouched.
                            state_d = S_DONE;
                            res_d   = {src1, 32'hFFFF_FFFF};
                        end
                    end
                end
                S_MUL: begin
                    stallreq = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        res_d   = mul_result;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    stallreq = 1'b1;
                    if (div_ready) begin
                        state_d = S_DONE;
                        res_d   = div_result;
                    end else begin
                        div_start = 1'b1;
                    end
                end
                S_DONE: begin
                    hilo_we = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mul_ina    = src1_q;
    assign mul_inb    = src2_q;
    assign mul_signed = (state_q == S_MUL) && (type_q == 2'b00);
    assign div_op1    = src1_q;
    assign div_op2    = src2_q;
    assign div_signed = (type_q == 2'b10);
    assign hi_wdata   = res_q[63:32];
    assign lo_wdata   = res_q[31:0];
    assign busy       = (state_q != S_IDLE);

endmodule
